// File: rtl/exu_phase_ctrl.sv
// -----------------------------------------------------------------------------
// exu_phase_ctrl
//
// Multi-cycle phase sequencer for the execute unit. Accepts one decoded
// instruction at a time and steps the execute unit's phase-select through
// read rs1, read rs2, memory access, writeback, PC writeback and release.
// The memory phase is stretched until mem_ack. The core stops permanently
// (until rst) on ebreak, an unknown instruction (halt), or a memory timeout.
//
// Parameters:
//   MEM_TIMEOUT  max MWAIT cycles before a timeout stop (1..255)
//   CNT_W        performance counter width (only used with the perf option)
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   inst_valid   decode stage presents an instruction
//   inst_ready   controller can accept an instruction (high only in IDLE)
//   inst_is_mem  instruction is a load/store, sampled on accept
//   exu_en[2:0]  phase select to the execute unit
//   mem_ack      memory access complete
//   halt         execute unit flag: unknown instruction
//   ebreak       execute unit flag: program exit
//   retire       one-cycle pulse per completed instruction
//   stopped      core stopped, sticky until rst
//   stop_cause   00 none, 01 ebreak, 10 halt, 11 memory timeout
//   dbg_state    current FSM state, for debug and checker binding
//   cycle_cnt    (perf option) cycles spent outside IDLE and STOP
//   inst_cnt     (perf option) retired instructions
//
// Optional feature: define EXU_PHASE_CTRL_PERF_EN to add the cycle_cnt and
// inst_cnt performance counters. Without it those ports do not exist.
//
// Handshake: an instruction transfers on a rising edge where inst_valid and
// inst_ready are both high. inst_ready is high only while IDLE, so the
// decode stage may raise or drop inst_valid freely while the controller is
// busy; nothing is sampled until the controller is back in IDLE.
// -----------------------------------------------------------------------------
module exu_phase_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             inst_is_mem,
  output logic [2:0]       exu_en,
  input  logic             mem_ack,
  input  logic             halt,
  input  logic             ebreak,
  output logic             retire,
  output logic             stopped,
  output logic [1:0]       stop_cause,
  output logic [3:0]       dbg_state
`ifdef EXU_PHASE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
`endif
);

  // Elaboration-time parameter sanity checks.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("exu_phase_ctrl: MEM_TIMEOUT must be in 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("exu_phase_ctrl: CNT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_P0    = 4'd1,
    S_P1    = 4'd2,
    S_P2    = 4'd3,
    S_MWAIT = 4'd4,
    S_P3    = 4'd5,
    S_P4    = 4'd6,
    S_REL   = 4'd7,
    S_STOP  = 4'd8
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_EBREAK  = 2'b01;
  localparam logic [1:0] CAUSE_HALT    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Last wait-counter value before the timeout fires.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       is_mem_q, is_mem_d;
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_d;

  // Phase select for a given state. MWAIT re-issues the memory phase; the
  // execute unit treats the repeat as idempotent.
  function automatic logic [2:0] phase_sel(input state_t s);
    logic [2:0] sel;
    sel = 3'b111;
    case (s)
      S_P0:    sel = 3'b000;
      S_P1:    sel = 3'b001;
      S_P2:    sel = 3'b010;
      S_MWAIT: sel = 3'b010;
      S_P3:    sel = 3'b011;
      S_P4:    sel = 3'b100;
      default: sel = 3'b111;
    endcase
    return sel;
  endfunction

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    is_mem_d = is_mem_q;
    wait_d   = wait_q;
    cause_d  = stop_cause;
    unique case (state_q)
      S_IDLE: begin
        if (inst_valid && inst_ready) begin
          is_mem_d = inst_is_mem;
          state_d  = S_P0;
        end
      end
      S_P0: state_d = S_P1;
      S_P1: state_d = S_P2;
      S_P2: begin
        if (!is_mem_q || mem_ack) begin
          state_d = S_P3;
        end else begin
          wait_d  = 8'd0;
          state_d = S_MWAIT;
        end
      end
      S_MWAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = S_P3;
        end else if (wait_q == WAIT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_STOP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_P3: state_d = S_P4;
      S_P4: begin
        // Flags are produced by the execute unit on the edge ending P3.
        if (ebreak) begin
          cause_d = CAUSE_EBREAK;
          state_d = S_STOP;
        end else if (halt) begin
          cause_d = CAUSE_HALT;
          state_d = S_STOP;
        end else begin
          state_d = S_REL;
        end
      end
      S_REL:  state_d = S_IDLE;
      S_STOP: state_d = S_STOP;
      default: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // State register. Outputs are registered from the next state so that
  // they line up with the state they describe on every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_mem_q   <= 1'b0;
      wait_q     <= 8'd0;
      exu_en     <= 3'b111;
      inst_ready <= 1'b1;
      retire     <= 1'b0;
      stopped    <= 1'b0;
      stop_cause <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      is_mem_q   <= is_mem_d;
      wait_q     <= wait_d;
      exu_en     <= phase_sel(state_d);
      inst_ready <= (state_d == S_IDLE);
      retire     <= (state_d == S_REL);
      stopped    <= (state_d == S_STOP);
      stop_cause <= cause_d;
    end
  end

  assign dbg_state = state_q;

`ifdef EXU_PHASE_CTRL_PERF_EN
  // Counters freeze in STOP because the busy condition excludes STOP and
  // retire can never be high there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_STOP) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (retire) begin
        inst_cnt <= inst_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
